// File: rtl/spi_transfer_arbiter.sv
// spi_transfer_arbiter: shares one SPI master between N_REQ requesters.
// Round-robin grant, one SPI transfer per grant, response handshake,
// watchdog on a hung transfer and an idle guard time between transfers.
//
//   state       | meaning
//   ------------+--------------------------------------------------------
//   S_IDLE      | waiting for any req_valid; grants and latches MOSI word
//   S_LAUNCH    | one-cycle spi_start pulse, watchdog counter cleared
//   S_WAIT_DONE | waiting for spi_done or watchdog terminal count
//   S_RESPOND   | resp_* held until resp_ready
//   S_GUARD     | GUARD_CYCLES idle clocks before the next grant
module spi_transfer_arbiter #(
    parameter int N_REQ          = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int GUARD_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]              req_ready,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [DATA_WIDTH-1:0]         resp_data,
    output logic [$clog2(N_REQ)-1:0]      resp_id,
    output logic                          resp_error,
    output logic                          spi_start,
    output logic [DATA_WIDTH-1:0]         spi_data_out,
    input  logic                          spi_done,
    input  logic [DATA_WIDTH-1:0]         spi_data_in,
    output logic                          busy
);

    localparam int ID_W    = $clog2(N_REQ);
    localparam int CW      = ID_W + 1;
    localparam int CNT_MAX = (GUARD_CYCLES > TIMEOUT_CYCLES) ? GUARD_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_DONE,
        S_RESPOND,
        S_GUARD
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   owner;
    logic [CNT_W-1:0]  cnt;
    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [CW-1:0]     cand;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = {1'b0, rr_ptr} + CW'(k);
            if (cand >= CW'(N_REQ)) begin
                cand = cand - CW'(N_REQ);
            end
            if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[ID_W-1:0];
            end
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the combinational strobes (req_ready, spi_start).
    always_comb begin
        state_next = state;
        req_ready  = '0;
        spi_start  = 1'b0;
        case (state)
            S_IDLE: begin
                if (grant_found) begin
                    // Gated by reset so every output reads 0 while reset is held.
                    req_ready[grant_idx] = reset;
                    state_next           = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                spi_start  = 1'b1;
                state_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (spi_done || cnt == TO_LAST) begin
                    state_next = S_RESPOND;
                end
            end
            S_RESPOND: begin
                if (resp_ready) begin
                    state_next = (GUARD_CYCLES == 0) ? S_IDLE : S_GUARD;
                end
            end
            S_GUARD: begin
                if (cnt == GUARD_LAST) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath: grant pointer, MOSI latch, shared saturating counter, response registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr       <= ID_W'(N_REQ - 1);
            owner        <= '0;
            cnt          <= '0;
            spi_data_out <= '0;
            resp_valid   <= 1'b0;
            resp_data    <= '0;
            resp_id      <= '0;
            resp_error   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        rr_ptr       <= grant_idx;
                        owner        <= grant_idx;
                        spi_data_out <= req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                S_LAUNCH: begin
                    cnt <= '0;
                end
                S_WAIT_DONE: begin
                    if (spi_done) begin
                        resp_data  <= spi_data_in;
                        resp_id    <= owner;
                        resp_error <= 1'b0;
                        resp_valid <= 1'b1;
                    end else if (cnt == TO_LAST) begin
                        resp_data  <= '0;
                        resp_id    <= owner;
                        resp_error <= 1'b1;
                        resp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_RESPOND: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        cnt        <= '0;
                    end
                end
                S_GUARD: begin
                    if (cnt != GUARD_LAST) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    assign busy = (state != S_IDLE);

endmodule
